paint_draw_ctrl: RTL

Sequencing controller between the paint UI and the shared rectangle rasterizer / VGA write port. It captures two cursor corners, launches the rectangle rasterizer and forwards its pixel stream to the VGA adapter with a registered plot strobe. It also owns a full-screen clear sweep that shares the same VGA write port. Clear requests that arrive while the port is busy are queued.

---
 rtl/paint_draw_if.sv | 41 ++++
 rtl/paint_draw_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/paint_draw_if.sv
// paint_draw_if
// Bundles the paint UI, rasterizer and VGA write-port signals of paint_draw_ctrl.
//   master : UI / rasterizer side. Drives the cursor, the request pulses and the pixel stream.
//   slave  : the controller. Drives the rasterizer request, the corners, the VGA write and the status flags.
interface paint_draw_if;
   logic [7:0] cursor_x;
   logic [7:0] cursor_y;
   logic [2:0] colour_in;
   logic       corner_set;
   logic       cancel;
   logic       clear_req;
   logic       rast_done;
   logic [7:0] rast_x;
   logic [7:0] rast_y;
   logic       rast_start;
   logic [7:0] rast_x0;
   logic [7:0] rast_y0;
   logic [7:0] rast_x1;
   logic [7:0] rast_y1;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_colour;
   logic       vga_plot;
   logic       busy;
   logic       armed;
   logic       draw_done;

   modport master (
      output cursor_x, cursor_y, colour_in, corner_set, cancel, clear_req,
             rast_done, rast_x, rast_y,
      input  rast_start, rast_x0, rast_y0, rast_x1, rast_y1,
             vga_x, vga_y, vga_colour, vga_plot, busy, armed, draw_done
   );

   modport slave (
      input  cursor_x, cursor_y, colour_in, corner_set, cancel, clear_req,
             rast_done, rast_x, rast_y,
      output rast_start, rast_x0, rast_y0, rast_x1, rast_y1,
             vga_x, vga_y, vga_colour, vga_plot, busy, armed, draw_done
   );
endinterface

// File: rtl/paint_draw_ctrl.sv
// paint_draw_ctrl
// Sequences the paint UI onto the shared rectangle rasterizer and the VGA write port.
// It captures two cursor corners, runs the rasterizer and forwards its pixels with a
// registered plot strobe. It also owns a full-screen clear sweep, and holds one clear
// request queued while the port is busy.
// Ports:
//   clk     system clock
//   resetn  asynchronous active-low reset
//   bus     paint_draw_if.slave: UI inputs, rasterizer handshake, VGA write, status
//
// state    | meaning
// ---------+------------------------------------------------------
// S_IDLE   | nothing running; accepts clear or corner 1
// S_ARMED  | corner 1 latched, waiting for corner 2
// S_LAUNCH | rast_start high, waiting for rast_done to drop (watchdog)
// S_DRAW   | forwarding the rasterizer pixel stream
// S_CLEAR  | full-screen sweep with CLEAR_COLOUR
module paint_draw_ctrl #(
   parameter int         SCREEN_W     = 160,
   parameter int         SCREEN_H     = 120,
   parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
   input logic         clk,
   input logic         resetn,
   paint_draw_if.slave bus
);
   localparam logic [7:0] X_MAX   = 8'(SCREEN_W - 1);
   localparam logic [7:0] Y_MAX   = 8'(SCREEN_H - 1);
   localparam logic [6:0] CY_MAX  = 7'(SCREEN_H - 1);
   localparam logic [3:0] WD_LOAD = 4'd15;

   typedef enum logic [2:0] {S_IDLE, S_ARMED, S_LAUNCH, S_DRAW, S_CLEAR} state_t;

   state_t     state, state_nxt;
   logic [3:0] wd_cnt;
   logic [7:0] cx;
   logic [6:0] cy;
   logic       clear_pend;
   logic [2:0] colour_q;
   logic       latch_c1, latch_c2, fwd_pix, clr_pix, op_done, pend_set, pend_clr;
   logic [7:0] cur_x_clamp, cur_y_clamp;
   logic       unused_rast_y7;

   assign cur_x_clamp    = (bus.cursor_x > X_MAX) ? X_MAX : bus.cursor_x;
   assign cur_y_clamp    = (bus.cursor_y > Y_MAX) ? Y_MAX : bus.cursor_y;
   assign unused_rast_y7 = bus.rast_y[7];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= S_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      latch_c1  = 1'b0;
      latch_c2  = 1'b0;
      fwd_pix   = 1'b0;
      clr_pix   = 1'b0;
      op_done   = 1'b0;
      pend_set  = 1'b0;
      pend_clr  = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.clear_req || clear_pend) begin
               state_nxt = S_CLEAR;
               pend_clr  = 1'b1;
            end else if (bus.corner_set) begin
               latch_c1  = 1'b1;
               state_nxt = S_ARMED;
            end
         end
         S_ARMED: begin
            if (bus.clear_req)       state_nxt = S_CLEAR;
            else if (bus.cancel)     state_nxt = S_IDLE;
            else if (bus.corner_set) begin
               latch_c2  = 1'b1;
               state_nxt = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            pend_set = bus.clear_req;
            // The first pixel arrives together with rast_done falling, so it is
            // forwarded from here to keep the one-cycle latency.
            if (!bus.rast_done) begin
               fwd_pix   = 1'b1;
               state_nxt = S_DRAW;
            end else if (wd_cnt == '0) begin
               op_done   = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         S_DRAW: begin
            pend_set = bus.clear_req;
            if (bus.rast_done) begin
               op_done   = 1'b1;
               state_nxt = S_IDLE;
            end else begin
               fwd_pix = 1'b1;
            end
         end
         S_CLEAR: begin
            pend_set = bus.clear_req;
            clr_pix  = 1'b1;
            if (cx == X_MAX && cy == CY_MAX) begin
               op_done   = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wd_cnt         <= WD_LOAD;
         cx             <= '0;
         cy             <= '0;
         clear_pend     <= 1'b0;
         colour_q       <= '0;
         bus.rast_start <= 1'b0;
         bus.rast_x0    <= '0;
         bus.rast_y0    <= '0;
         bus.rast_x1    <= '0;
         bus.rast_y1    <= '0;
         bus.vga_x      <= '0;
         bus.vga_y      <= '0;
         bus.vga_colour <= '0;
         bus.vga_plot   <= 1'b0;
         bus.busy       <= 1'b0;
         bus.armed      <= 1'b0;
         bus.draw_done  <= 1'b0;
      end else begin
         // Watchdog: sits at the load value outside LAUNCH, reaches zero on the 16th LAUNCH cycle.
         if (state != S_LAUNCH)  wd_cnt <= WD_LOAD;
         else if (wd_cnt != '0)  wd_cnt <= wd_cnt - 4'd1;

         // The sweep counters wrap to (0,0) after the last pixel, ready for the next clear.
         if (clr_pix) begin
            if (cx == X_MAX) begin
               cx <= '0;
               cy <= (cy == CY_MAX) ? '0 : cy + 7'd1;
            end else begin
               cx <= cx + 8'd1;
            end
         end

         if (pend_clr)      clear_pend <= 1'b0;
         else if (pend_set) clear_pend <= 1'b1;

         if (latch_c1) begin
            bus.rast_x0 <= cur_x_clamp;
            bus.rast_y0 <= cur_y_clamp;
         end
         if (latch_c2) begin
            bus.rast_x1 <= cur_x_clamp;
            bus.rast_y1 <= cur_y_clamp;
            colour_q    <= bus.colour_in;
         end

         bus.vga_plot <= fwd_pix | clr_pix;
         if (fwd_pix) begin
            bus.vga_x      <= bus.rast_x;
            bus.vga_y      <= bus.rast_y[6:0];
            bus.vga_colour <= colour_q;
         end else if (clr_pix) begin
            bus.vga_x      <= cx;
            bus.vga_y      <= cy;
            bus.vga_colour <= CLEAR_COLOUR;
         end

         bus.rast_start <= (state_nxt == S_LAUNCH) || (state_nxt == S_DRAW);
         bus.busy       <= (state_nxt == S_LAUNCH) || (state_nxt == S_DRAW) || (state_nxt == S_CLEAR);
         bus.armed      <= (state_nxt == S_ARMED);
         bus.draw_done  <= op_done;
      end
   end
endmodule
